// File: rtl/step_sequencer_pkg.sv
// Shared types and defaults for the step-size sequencer and its WAIT timer.
package step_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLAMP,
        S_LOAD,
        S_INIT,
        S_START,
        S_WAIT,
        S_ACCEPT,
        S_REJECT,
        S_DONE,
        S_FAIL
    } state_t;

    localparam int unsigned DEFAULT_MAX_RETRIES = 8;
    localparam int unsigned DEFAULT_TIMEOUT     = 1023;

    // Result flags returned by the step module alongside step_out.
    typedef struct packed {
        logic done;
        logic proceed;
        logic error;
    } step_status_t;

    // An error report overrides proceed: such a step is retried.
    function automatic logic step_accepted(input step_status_t s);
        return s.proceed && !s.error;
    endfunction

endpackage

// File: rtl/step_sequencer_timer.sv
// WAIT-state timeout counter: expired is high during the LIMIT-th enabled cycle after clear.
module step_timer #(
    parameter int unsigned LIMIT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/step_sequencer.sv
// Initiator for the adaptive step-size module: walks time from t0 to t_end,
// retrying rejected steps and ping-ponging state-vector buffers on accepted ones.
module step_sequencer
    import step_sequencer_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = 16,
    parameter int unsigned ADDRESS_SIZE = 16,
    parameter int unsigned MAX_RETRIES  = DEFAULT_MAX_RETRIES,
    parameter int unsigned TIMEOUT      = DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go,
    input  logic [WORD_SIZE-1:0]    t0,
    input  logic [WORD_SIZE-1:0]    t_end,
    input  logic [WORD_SIZE-1:0]    h0,
    input  logic [ADDRESS_SIZE-1:0] x_base_a,
    input  logic [ADDRESS_SIZE-1:0] x_base_b,
    output logic                    step_init,
    output logic                    step_start,
    output logic                    step_read,
    output logic [WORD_SIZE-1:0]    step_in,
    output logic [ADDRESS_SIZE-1:0] x0_address,
    output logic [ADDRESS_SIZE-1:0] x1_address,
    input  logic                    step_done,
    input  logic                    step_proceed,
    input  logic                    step_error,
    input  logic [WORD_SIZE-1:0]    step_out,
    output logic                    busy,
    output logic                    finished,
    output logic                    failed,
    output logic [WORD_SIZE-1:0]    t_now,
    output logic [WORD_SIZE-1:0]    h_now,
    output logic [WORD_SIZE-1:0]    accept_count,
    output logic [WORD_SIZE-1:0]    reject_count
);

    localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

    state_t               state;
    step_status_t         status;
    logic [WORD_SIZE-1:0] t_end_q;
    logic [WORD_SIZE-1:0] step_out_q;
    logic [WORD_SIZE-1:0] remaining;
    logic [WORD_SIZE-1:0] h_clamped;
    logic [WORD_SIZE-1:0] t_next;
    logic [RW-1:0]        retry_count;
    logic [RW-1:0]        retry_next;
    logic                 first_step;
    logic                 timer_clear;
    logic                 timer_enable;
    logic                 timer_expired;

    // t_now never passes t_end_q, so remaining cannot wrap.
    always_comb begin
        status     = '{done: step_done, proceed: step_proceed, error: step_error};
        remaining  = t_end_q - t_now;
        h_clamped  = (remaining < h_now) ? remaining : h_now;
        t_next     = t_now + h_now;
        retry_next = retry_count + RW'(1);
    end

    assign timer_clear  = (state == S_START);
    assign timer_enable = (state == S_WAIT);

    step_timer #(
        .LIMIT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            step_init    <= 1'b0;
            step_start   <= 1'b0;
            step_read    <= 1'b0;
            step_in      <= '0;
            x0_address   <= '0;
            x1_address   <= '0;
            busy         <= 1'b0;
            finished     <= 1'b0;
            failed       <= 1'b0;
            t_now        <= '0;
            h_now        <= '0;
            accept_count <= '0;
            reject_count <= '0;
            t_end_q      <= '0;
            step_out_q   <= '0;
            retry_count  <= '0;
            first_step   <= 1'b0;
        end else begin
            step_init  <= 1'b0;
            step_start <= 1'b0;
            step_read  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        t_end_q      <= t_end;
                        t_now        <= t0;
                        h_now        <= h0;
                        x0_address   <= x_base_a;
                        x1_address   <= x_base_b;
                        accept_count <= '0;
                        reject_count <= '0;
                        retry_count  <= '0;
                        finished     <= 1'b0;
                        failed       <= 1'b0;
                        first_step   <= 1'b1;
                        busy         <= 1'b1;
                        state        <= (h0 == '0 || t0 >= t_end) ? S_FAIL : S_CLAMP;
                    end
                end
                // Pulses are registered, so each is raised on the edge entering its state.
                S_CLAMP: begin
                    h_now     <= h_clamped;
                    step_in   <= h_clamped;
                    step_read <= 1'b1;
                    state     <= S_LOAD;
                end
                S_LOAD: begin
                    if (first_step) begin
                        first_step <= 1'b0;
                        step_init  <= 1'b1;
                        state      <= S_INIT;
                    end else begin
                        step_start <= 1'b1;
                        state      <= S_START;
                    end
                end
                S_INIT: begin
                    step_start <= 1'b1;
                    state      <= S_START;
                end
                S_START: state <= S_WAIT;
                S_WAIT: begin
                    if (status.done) begin
                        step_out_q <= step_out;
                        state      <= step_accepted(status) ? S_ACCEPT : S_REJECT;
                    end else if (timer_expired) begin
                        state <= S_FAIL;
                    end
                end
                S_ACCEPT: begin
                    t_now        <= t_next;
                    x0_address   <= x1_address;
                    x1_address   <= x0_address;
                    accept_count <= accept_count + WORD_SIZE'(1);
                    retry_count  <= '0;
                    h_now        <= step_out_q;
                    if (t_next == t_end_q)        state <= S_DONE;
                    else if (step_out_q == '0)    state <= S_FAIL;
                    else                          state <= S_CLAMP;
                end
                S_REJECT: begin
                    reject_count <= reject_count + WORD_SIZE'(1);
                    retry_count  <= retry_next;
                    h_now        <= step_out_q;
                    if (32'(retry_next) >= MAX_RETRIES || step_out_q == '0) state <= S_FAIL;
                    else                                                    state <= S_CLAMP;
                end
                S_DONE: begin
                    finished <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                S_FAIL: begin
                    failed <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
